// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: a Moore FSM that steps the shared datapath
// through fetch/decode/execute/memory/writeback and counts retired instructions.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 when memory is ready
// DECODE   | dispatch on OpCode, precompute branch target
// MEMADR   | compute lw/sw address
// MEMREAD  | load data access, wait for memory
// MEMWB    | write load data to rt, retire
// MEMWRITE | store data access, retire on memory ready
// EXECUTE  | R-type ALU op
// ALUWB    | write ALU result to rd, retire
// BRANCH   | beq compare, PC <- target when zero, retire
// ADDIEX   | addi ALU op
// ADDIWB   | write addi result to rt, retire
// JUMP     | PC <- jump target, retire
module multicycle_control_fsm #(
  parameter int CNT_WIDTH     = 32,
  parameter int USE_MEM_READY = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           Funct,
  input  logic                 ZeroFlag,
  input  logic                 Mem_Ready,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PC_En,
  output logic                 IorD,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSrc,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [2:0]           ALUControl,
  output logic                 Illegal_Op,
  output logic [CNT_WIDTH-1:0] Instr_Count,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_WIDTH-1:0]   r_instr_count;
  logic                   w_mem_ready;
  logic                   w_funct_ok;
  logic [2:0]             w_funct_alu;
  logic                   w_retire;
  logic                   w_pcwrite;
  logic                   w_branch;
  logic                   w_memwrite;
  logic                   w_irwrite;
  logic                   w_regwrite;
  logic                   w_illegal;

  assign w_mem_ready = (USE_MEM_READY != 0) ? Mem_Ready : 1'b1;

  always_comb begin
    w_funct_ok  = 1'b1;
    w_funct_alu = 3'b010;
    case (Funct)
      6'b100000: w_funct_alu = 3'b010;
      6'b100010: w_funct_alu = 3'b110;
      6'b100100: w_funct_alu = 3'b000;
      6'b100101: w_funct_alu = 3'b001;
      6'b101010: w_funct_alu = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_FETCH;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instr_count <= r_instr_count + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_next     = S_FETCH;
    w_retire   = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_illegal  = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUControl = 3'b010;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        w_irwrite = w_mem_ready;
        w_pcwrite = w_mem_ready;
        w_next    = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (w_funct_ok) w_next = S_EXECUTE;
            else            w_illegal = 1'b1;
          end
          OP_BEQ:  w_next = S_BRANCH;
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JUMP;
          default: w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (OpCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        IorD   = 1'b1;
        w_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = w_mem_ready;
        w_next     = w_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_funct_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 3'b110;
        PCSrc      = 2'b01;
        w_branch   = 1'b1;
        w_retire   = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
        w_retire  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset overrides every side effect so an aborted instruction leaves no trace.
  assign MemWrite    = w_memwrite & ~RST;
  assign IRWrite     = w_irwrite & ~RST;
  assign PC_En       = (w_pcwrite | (w_branch & ZeroFlag)) & ~RST;
  assign RegWrite    = w_regwrite & ~RST;
  assign Illegal_Op  = w_illegal & ~RST;
  assign Instr_Count = r_instr_count;
  assign State       = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: expected per-cycle outputs are queued
// as stimulus is applied and compared against the DUT mid-cycle.
module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] OpCode, Funct;
  logic       ZeroFlag, Mem_Ready;
  logic       MemWrite, IRWrite, PC_En, IorD, ALUSrcA, RegDst, MemtoReg, RegWrite, Illegal_Op;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] Instr_Count;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic       rw, mw, irw, pce, ill, rdst;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  multicycle_control_fsm #(.CNT_WIDTH(4), .USE_MEM_READY(1)) dut (
    .CLK(CLK), .RST(RST), .OpCode(OpCode), .Funct(Funct), .ZeroFlag(ZeroFlag),
    .Mem_Ready(Mem_Ready), .MemWrite(MemWrite), .IRWrite(IRWrite), .PC_En(PC_En),
    .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .Illegal_Op(Illegal_Op), .Instr_Count(Instr_Count), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input string field, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic [5:0] fn, input logic z, input logic mr,
                     input logic [3:0] st, input logic rw, input logic mw,
                     input logic irw, input logic pce, input logic ill,
                     input logic rdst, input logic [2:0] alu, input logic [1:0] pcs,
                     input logic [3:0] cnt);
    exp_t e;
    exp_t g;
    RST = rst; OpCode = op; Funct = fn; ZeroFlag = z; Mem_Ready = mr;
    e.tag = tag; e.st = st; e.rw = rw; e.mw = mw; e.irw = irw; e.pce = pce;
    e.ill = ill; e.rdst = rdst; e.alu = alu; e.pcs = pcs; e.cnt = cnt;
    exp_q.push_back(e);
    @(negedge CLK);
    g = exp_q.pop_front();
    chk(g.tag, "State",       State,               g.st);
    chk(g.tag, "RegWrite",    {3'b0, RegWrite},    {3'b0, g.rw});
    chk(g.tag, "MemWrite",    {3'b0, MemWrite},    {3'b0, g.mw});
    chk(g.tag, "IRWrite",     {3'b0, IRWrite},     {3'b0, g.irw});
    chk(g.tag, "PC_En",       {3'b0, PC_En},       {3'b0, g.pce});
    chk(g.tag, "Illegal_Op",  {3'b0, Illegal_Op},  {3'b0, g.ill});
    chk(g.tag, "RegDst",      {3'b0, RegDst},      {3'b0, g.rdst});
    chk(g.tag, "ALUControl",  {1'b0, ALUControl},  {1'b0, g.alu});
    chk(g.tag, "PCSrc",       {2'b0, PCSrc},       {2'b0, g.pcs});
    chk(g.tag, "Instr_Count", Instr_Count,         g.cnt);
    @(posedge CLK);
    #1;
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] SUB = 6'b100010, ADD = 6'b100000;

  initial begin
    RST = 1'b1; OpCode = LW; Funct = ADD; ZeroFlag = 1'b0; Mem_Ready = 1'b1;
    @(posedge CLK);
    #1;
    //   tag          rst op    fn     z  mr  st rw mw irw pce ill rd alu     pcs    cnt
    cyc("rst0",       1, LW,   ADD,  0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0);
    cyc("rst1",       1, LW,   ADD,  0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0);
    // lw, no stalls
    cyc("lw_fetch",   0, LW,   ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 0);
    cyc("lw_decode",  0, LW,   ADD,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0);
    cyc("lw_memadr",  0, LW,   ADD,  0, 1, 2, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0);
    cyc("lw_memread", 0, LW,   ADD,  0, 1, 3, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0);
    cyc("lw_memwb",   0, LW,   ADD,  0, 1, 4, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0);
    // R-type sub
    cyc("sub_fetch",  0, RT,   SUB,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 1);
    cyc("sub_decode", 0, RT,   SUB,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 1);
    cyc("sub_exec",   0, RT,   SUB,  0, 1, 6, 0, 0, 0, 0, 0, 0, 3'b110, 2'b00, 1);
    cyc("sub_aluwb",  0, RT,   SUB,  0, 1, 7, 1, 0, 0, 0, 0, 1, 3'b010, 2'b00, 1);
    // beq taken then not taken
    cyc("beqt_fetch", 0, BEQ,  ADD,  1, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 2);
    cyc("beqt_dec",   0, BEQ,  ADD,  1, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 2);
    cyc("beqt_br",    0, BEQ,  ADD,  1, 1, 8, 0, 0, 0, 1, 0, 0, 3'b110, 2'b01, 2);
    cyc("beqn_fetch", 0, BEQ,  ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 3);
    cyc("beqn_dec",   0, BEQ,  ADD,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 3);
    cyc("beqn_br",    0, BEQ,  ADD,  0, 1, 8, 0, 0, 0, 0, 0, 0, 3'b110, 2'b01, 3);
    // sw with a 3-cycle memory stall, then a stalled fetch
    cyc("sw_fetch",   0, SW,   ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 4);
    cyc("sw_decode",  0, SW,   ADD,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 4);
    cyc("sw_memadr",  0, SW,   ADD,  0, 1, 2, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 4);
    cyc("sw_wait0",   0, SW,   ADD,  0, 0, 5, 0, 1, 0, 0, 0, 0, 3'b010, 2'b00, 4);
    cyc("sw_wait1",   0, SW,   ADD,  0, 0, 5, 0, 1, 0, 0, 0, 0, 3'b010, 2'b00, 4);
    cyc("sw_wait2",   0, SW,   ADD,  0, 0, 5, 0, 1, 0, 0, 0, 0, 3'b010, 2'b00, 4);
    cyc("sw_done",    0, SW,   ADD,  0, 1, 5, 0, 1, 0, 0, 0, 0, 3'b010, 2'b00, 4);
    cyc("fst_wait0",  0, ADDI, ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 5);
    cyc("fst_wait1",  0, ADDI, ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 5);
    // addi after the stalled fetch
    cyc("addi_fetch", 0, ADDI, ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 5);
    cyc("addi_dec",   0, ADDI, ADD,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 5);
    cyc("addi_ex",    0, ADDI, ADD,  0, 1, 9, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 5);
    cyc("addi_wb",    0, ADDI, ADD,  0, 1, 10, 1, 0, 0, 0, 0, 0, 3'b010, 2'b00, 5);
    // illegal opcode, then illegal R-type funct
    cyc("ill_fetch",  0, 6'b111111, ADD, 0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 6);
    cyc("ill_dec",    0, 6'b111111, ADD, 0, 1, 1, 0, 0, 0, 0, 1, 0, 3'b010, 2'b00, 6);
    cyc("illf_fetch", 0, RT, 6'b000000,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 6);
    cyc("illf_dec",   0, RT, 6'b000000,  0, 1, 1, 0, 0, 0, 0, 1, 0, 3'b010, 2'b00, 6);
    // jump
    cyc("j_fetch",    0, J,    ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 6);
    cyc("j_dec",      0, J,    ADD,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 6);
    cyc("j_jump",     0, J,    ADD,  0, 1, 11, 0, 0, 0, 1, 0, 0, 3'b010, 2'b10, 6);
    // reset in the middle of a stalled load
    cyc("lwr_fetch",  0, LW,   ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 7);
    cyc("lwr_dec",    0, LW,   ADD,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 7);
    cyc("lwr_adr",    0, LW,   ADD,  0, 1, 2, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 7);
    cyc("lwr_wait",   0, LW,   ADD,  0, 0, 3, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 7);
    cyc("lwr_rst",    1, LW,   ADD,  0, 1, 3, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 7);
    cyc("lwr_rstf",   1, LW,   ADD,  0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, 0);
    // run jumps from 0 through all-ones and observe the wrap
    for (int k = 0; k < 16; k++) begin
      logic [3:0] c;
      c = 4'(k);
      cyc("wrap_fetch", 0, J, ADD, 0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, c);
      cyc("wrap_dec",   0, J, ADD, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 2'b00, c);
      cyc("wrap_jump",  0, J, ADD, 0, 1, 11, 0, 0, 0, 1, 0, 0, 3'b010, 2'b10, c);
    end
    cyc("wrap_zero",  0, J,    ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 3'b010, 2'b00, 0);
    checks++;
    assert (exp_q.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the MIPS core. It replaces the single-cycle combinational control with a Moore FSM that steps the shared datapath through fetch, decode, execute, memory and writeback, one step per clock. It owns the memory wait handshake, PC enable, retired-instruction counting and illegal-opcode reporting. It sits between the instruction register outputs (OpCode/Funct), the ALU ZeroFlag and the unified instruction/data memory.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter.
USE_MEM_READY, 1, 1 = memory states wait for Mem_Ready; 0 = Mem_Ready treated as constant 1.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  synchronous, active-high reset.
OpCode  input  6  Instr[31:26] from instruction register.
Funct  input  6  Instr[5:0].
ZeroFlag  input  1  ALU zero.
Mem_Ready  input  1  memory access completes this cycle.
MemWrite  output  1  data memory write enable.
IRWrite  output  1  instruction register load.
PC_En  output  1  PC load = PCWrite | (Branch & ZeroFlag).
IorD  output  1  0 = PC addresses memory, 1 = ALUOut.
ALUSrcA  output  1  0 = PC, 1 = RD1.
ALUSrcB  output  2  00 RD2, 01 const 4, 10 SignImm, 11 SignImm<<2.
PCSrc  output  2  00 ALUResult, 01 ALUOut, 10 jump target.
RegDst  output  1  1 = rd, 0 = rt.
MemtoReg  output  1  1 = memory data.
RegWrite  output  1  register file write enable.
ALUControl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
Illegal_Op  output  1  one-cycle pulse on an unsupported instruction.
Instr_Count  output  CNT_WIDTH  retired-instruction count.
State  output  4  current state, for debug.

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12–15 go to FETCH on the next edge.
- Reset: when RST=1 at an edge, State <= FETCH and Instr_Count <= 0. While RST=1, all write enables (MemWrite, IRWrite, PC_En, RegWrite) and Illegal_Op are forced to 0. Reset mid-instruction aborts the instruction; nothing is retired.
- Outputs are combinational from State, plus Mem_Ready, ZeroFlag and Funct. Unlisted outputs are 0; ALUControl defaults to 010.
- FETCH:
  - Drives IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00.
  - IRWrite and PCWrite equal Mem_Ready.
  - Stays in FETCH until Mem_Ready=1, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11 (precomputes branch target). Next state by OpCode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXECUTE when Funct is in {100000, 100010, 100100, 100101, 101010}.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Anything else, including an unsupported R-type Funct: Illegal_Op=1 for this cycle, next state FETCH, no retire.
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD=1. Waits for Mem_Ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Retires; next FETCH.
- MEMWRITE: IorD=1, MemWrite=1 held until Mem_Ready=1. Retires on the Mem_Ready cycle; next FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl from Funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111. Next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Retires; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1, so PC_En=ZeroFlag. Retires whether taken or not; next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Retires; next FETCH.
- JUMP: PCSrc=10, PCWrite=1. Retires; next FETCH.
- Instruction latency with Mem_Ready tied 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- Instr_Count increments by 1 on the edge that leaves a retiring state. It wraps from all-ones to 0.
- Mem_Ready has no effect outside FETCH, MEMREAD and MEMWRITE.

Test Plan:
- RST=1 for 2 cycles, then release with Mem_Ready=1 and opcode 100011 -> State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4. Instr_Count=1 after 5 cycles.
- R-type sub (OpCode 000000, Funct 100010) -> ALUControl=110 in EXECUTE. RegDst=1 and RegWrite=1 in ALUWB. 4 cycles.
- beq with ZeroFlag=1 -> PC_En=1 and PCSrc=01 in BRANCH. With ZeroFlag=0 -> PC_En=0. Count increments in both cases.
- sw with Mem_Ready low for 3 cycles in MEMWRITE -> MemWrite=1 held for 4 cycles. Retire only on the Mem_Ready cycle. FETCH stall likewise holds IRWrite=PC_En=0.
- OpCode 111111 -> Illegal_Op=1 for one cycle in DECODE, return to FETCH, Instr_Count unchanged.
- Assert RST during MEMREAD -> State=0 on the next edge, all write enables 0 during reset. With Instr_Count preset to all-ones (CNT_WIDTH=4, count 15), the next retire wraps it to 0.
